// File: rtl/alu_arbiter.sv
// Two-requester round-robin arbiter in front of a shared combinational ALU.
// Each operation takes three states: grant/latch (IDLE), execute (EXEC) and respond (RESP).
module alu_arbiter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0,
    input  logic [2:0]       op0,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic             req1,
    input  logic [2:0]       op1,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    output logic [2:0]       alu_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_y,
    output logic [WIDTH-1:0] y,
    output logic             done0,
    output logic             done1,
    output logic             gnt,
    output logic             busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_last;
    logic             w_last_nxt;
    logic             w_sel;
    logic [2:0]       w_alu_op_nxt;
    logic [WIDTH-1:0] w_alu_a_nxt;
    logic [WIDTH-1:0] w_alu_b_nxt;
    logic [WIDTH-1:0] w_y_nxt;
    logic             w_done0_nxt;
    logic             w_done1_nxt;
    logic             w_gnt_nxt;
    logic             w_busy_nxt;

    // State and all registered outputs; last starts at 1 so requester 0 wins first contention.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_last  <= 1'b1;
            alu_op  <= 3'd0;
            alu_a   <= '0;
            alu_b   <= '0;
            y       <= '0;
            done0   <= 1'b0;
            done1   <= 1'b0;
            gnt     <= 1'b0;
            busy    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_last  <= w_last_nxt;
            alu_op  <= w_alu_op_nxt;
            alu_a   <= w_alu_a_nxt;
            alu_b   <= w_alu_b_nxt;
            y       <= w_y_nxt;
            done0   <= w_done0_nxt;
            done1   <= w_done1_nxt;
            gnt     <= w_gnt_nxt;
            busy    <= w_busy_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (req0 || req1) w_state_nxt = S_EXEC;
            S_EXEC:  w_state_nxt = S_RESP;
            S_RESP:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Requester pick: a lone request wins, contention goes to whoever was not served last.
    assign w_sel = (req0 && req1) ? ~r_last : req1;

    // Output next values; registers hold unless the current state updates them.
    always_comb begin
        w_alu_op_nxt = alu_op;
        w_alu_a_nxt  = alu_a;
        w_alu_b_nxt  = alu_b;
        w_y_nxt      = y;
        w_gnt_nxt    = gnt;
        w_last_nxt   = r_last;
        w_done0_nxt  = 1'b0;
        w_done1_nxt  = 1'b0;
        w_busy_nxt   = (w_state_nxt != S_IDLE);
        case (r_state)
            S_IDLE: begin
                if (req0 || req1) begin
                    w_gnt_nxt    = w_sel;
                    w_alu_op_nxt = w_sel ? op1 : op0;
                    w_alu_a_nxt  = w_sel ? a1 : a0;
                    w_alu_b_nxt  = w_sel ? b1 : b0;
                end
            end
            S_EXEC: begin
                w_y_nxt     = alu_y;
                w_done0_nxt = ~gnt;
                w_done1_nxt = gnt;
            end
            S_RESP: begin
                w_last_nxt = gnt;
            end
            default: begin
                w_last_nxt = r_last;
            end
        endcase
    end

endmodule
